// File: rtl/thirty_two_bit_divider_pkg.sv
// Shared ALU definitions for the sequential restoring divider.
package thirty_two_bit_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam int unsigned ITER_COUNT        = 32;
  localparam logic [5:0]  LAST_ITER         = 6'(ITER_COUNT - 1);
  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/thirty_two_bit_divider_if.sv
// Request/result bundle between the ALU control and the divider.
interface thirty_two_bit_divider_if;

  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/thirty_two_bit_full_adder.sv
// 32-bit ripple-carry adder shared with the ALU adder datapath.
module thirty_two_bit_full_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = carry_in;
    for (int unsigned i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carry_out = carry;
  end

endmodule

// File: rtl/thirty_two_bit_divider.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock.
module thirty_two_bit_divider
  import thirty_two_bit_divider_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  thirty_two_bit_divider_if.slave     bus
);

  div_state_e  state_q, state_d;
  // Before the last iteration the partial remainder is below 2^31, so only
  // 31 bits are carried; the full 32-bit value goes straight to the result.
  logic [30:0] rem_q;
  logic [31:0] wq_q;
  logic [31:0] divisor_q;
  logic [5:0]  cnt_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        dbz_q;

  logic [31:0] shifted;
  logic [31:0] trial;
  logic        no_borrow;
  logic [31:0] next_rem;
  logic [31:0] next_wq;
  logic        last_iter;

  assign shifted = {rem_q, wq_q[31]};

  thirty_two_bit_full_adder u_trial_sub (
    .a         (shifted),
    .b         (~divisor_q),
    .carry_in  (1'b1),
    .sum       (trial),
    .carry_out (no_borrow)
  );

  // Restore-or-keep selection and quotient bit insertion.
  always_comb begin
    next_rem  = no_borrow ? trial : shifted;
    next_wq   = {wq_q[30:0], no_borrow};
    last_iter = (cnt_q == LAST_ITER);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = (bus.divisor == '0) ? DONE : RUN;
      RUN:  if (last_iter) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      wq_q        <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              rem_q     <= '0;
              wq_q      <= bus.dividend;
              cnt_q     <= '0;
              divisor_q <= bus.divisor;
            end else begin
              quotient_q  <= DIV_ZERO_QUOTIENT;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q <= next_rem[30:0];
          wq_q  <= next_wq;
          cnt_q <= cnt_q + 6'd1;
          if (last_iter) begin
            quotient_q  <= next_wq;
            remainder_q <= next_rem;
            dbz_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
